psp_icache: RTL and testbench



---
 rtl/psp_icache_pkg.sv | 14 +
 rtl/psp_icache_data_array.sv | 20 ++
 rtl/psp_icache.sv | 124 ++++++++++++
 tb/tb_psp_icache.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/psp_icache_pkg.sv
// psp_icache_pkg: shared state encoding, default geometry and address-field types for psp_icache.
package psp_icache_pkg;
  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_LINES = 16;
  localparam int DEF_LINE_WORDS = 4;
  localparam int OFFSET_W = $clog2(DEF_LINE_WORDS);
  localparam int INDEX_W = $clog2(DEF_NUM_LINES);
  localparam int TAG_W = DEF_ADDR_W - 2 - OFFSET_W - INDEX_W;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [OFFSET_W-1:0] offset_t;
endpackage

// File: rtl/psp_icache_data_array.sv
// psp_icache_data_array: line storage, one synchronous write port and one combinational read port.
module psp_icache_data_array
  import psp_icache_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_NUM_LINES * DEF_LINE_WORDS,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/psp_icache.sv
// psp_icache: direct-mapped read-only instruction cache in front of main-memory port A.
// Optional hit/miss counters are built when PSP_ICACHE_STATS_EN is defined.
module psp_icache
  import psp_icache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_data_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_data_i,
  input  logic [DATA_W-1:0] mem_data_o
`ifdef PSP_ICACHE_STATS_EN
  , output logic [31:0]     hit_count
  , output logic [31:0]     miss_count
`endif
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = ADDR_W - 2 - OW - IW;
  state_t state, state_n;
  logic [ADDR_W-1:2] addr_q;
  logic [TW-1:0] tags [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic [OW-1:0] issue_cnt, ret_cnt;
  logic issue_done, ret_en, last_ret, hit, accept;
  logic [DATA_W-1:0] resp_q, rd_data;
  logic [TW-1:0] req_tag;
  logic [IW-1:0] req_idx;
  logic [OW-1:0] req_off;
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_addr[1:0];
  assign req_tag = addr_q[ADDR_W-1 -: TW];
  assign req_idx = addr_q[2+OW +: IW];
  assign req_off = addr_q[2 +: OW];
  assign hit = valid[req_idx] && tags[req_idx] == req_tag;
  assign accept = req_valid && req_ready;
  assign last_ret = ret_en && ret_cnt == '1;
  assign mem_write_en = 1'b0;
  assign mem_data_i = '0;
  assign mem_addr = mem_data_en ? {req_tag, req_idx, issue_cnt, 2'b00} : '0;
  assign resp_data = resp_valid ? rd_data : resp_q;
  always_comb begin
    state_n = state;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    mem_data_en = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        state_n = req_valid ? LOOKUP : IDLE;
      end
      LOOKUP: begin
        req_ready = hit;
        resp_valid = hit;
        state_n = !hit ? REFILL : req_valid ? LOOKUP : IDLE;
      end
      REFILL: begin
        mem_data_en = !issue_done;
        state_n = last_ret ? RESPOND : REFILL;
      end
      RESPOND: begin
        resp_valid = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      valid <= '0;
      issue_cnt <= '0;
      ret_cnt <= '0;
      issue_done <= 1'b0;
      ret_en <= 1'b0;
      resp_q <= '0;
    end else begin
      state <= state_n;
      if (accept) addr_q <= req_addr[ADDR_W-1:2];
      ret_en <= mem_data_en;
      if (mem_data_en) issue_cnt <= issue_cnt + 1'b1;
      if (ret_en) ret_cnt <= ret_cnt + 1'b1;
      issue_done <= state_n == REFILL && (issue_done || (mem_data_en && issue_cnt == '1));
      // The victim line is invalid while it is being overwritten.
      if (state == LOOKUP && !hit) valid[req_idx] <= 1'b0;
      if (last_ret) valid[req_idx] <= 1'b1;
      if (resp_valid) resp_q <= rd_data;
    end
  always_ff @(posedge clk)
    if (last_ret) tags[req_idx] <= req_tag;
`ifdef PSP_ICACHE_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hit_count <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      hit_count <= hit_count + {31'd0, hit};
      miss_count <= miss_count + {31'd0, !hit};
    end
`endif
  psp_icache_data_array #(
    .DATA_W(DATA_W),
    .DEPTH(NUM_LINES * LINE_WORDS)
  ) u_data (
    .clk(clk),
    .we(ret_en),
    .waddr({req_idx, ret_cnt}),
    .wdata(mem_data_o),
    .raddr({req_idx, req_off}),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_psp_icache.sv
// tb_psp_icache: scoreboard bench for psp_icache with a synchronous memory model mem[a]=a^32'hA5A5_0000.
module tb_psp_icache;
  typedef struct {
    logic [31:0] v;
    int c;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic req_ready, resp_valid, mem_data_en, mem_write_en;
  logic [31:0] resp_data, mem_addr, mem_data_i;
  logic [31:0] mem_data_o = '0;
`ifdef PSP_ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];
  exp_t mem_q[$];
  psp_icache dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .mem_addr(mem_addr),
    .mem_data_en(mem_data_en),
    .mem_write_en(mem_write_en),
    .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o)
`ifdef PSP_ICACHE_STATS_EN
    , .hit_count(hit_count)
    , .miss_count(miss_count)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_data_en) mem_data_o <= mem_addr ^ 32'hA5A5_0000;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Monitor: every response and every memory read must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected resp_valid: data %h at cycle %0d", resp_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("resp_data", resp_data, e.v);
        chk("resp cycle", cyc, e.c);
      end
    end
    if (mem_data_en) begin
      if (mem_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected mem_data_en: addr %h at cycle %0d", mem_addr, cyc);
      end else begin
        e = mem_q.pop_front();
        chk("mem_addr", mem_addr, e.v);
        chk("mem cycle", cyc, e.c);
      end
    end
  end
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input bit miss);
    int w = 0;
    int acc;
    req_valid = 1'b1;
    req_addr = a;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready timeout: addr %h got 0 expected 1", a);
    end
    acc = cyc + 1;
    exp_q.push_back('{d, acc + (miss ? 6 : 0)});
    if (miss)
      for (int k = 0; k < 4; k++) mem_q.push_back('{(a & ~32'hF) + 32'(4 * k), acc + 1 + k});
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int t0;
    #1;
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset resp_data", resp_data, 32'd0);
    chk("reset mem_data_en", {31'd0, mem_data_en}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("mem_write_en", {31'd0, mem_write_en}, 32'd0);
    chk("mem_data_i", mem_data_i, 32'd0);
    idle(2);
    reset = 1'b0;
    idle(1);
    issue(32'h0000_0010, 32'hA5A5_0010, 1'b1);
    idle(8);
    issue(32'h0000_0018, 32'hA5A5_0018, 1'b0);
    idle(2);
    chk("resp_data hold", resp_data, 32'hA5A5_0018);
`ifdef PSP_ICACHE_STATS_EN
    chk("hit_count", hit_count, 32'd1);
    chk("miss_count", miss_count, 32'd1);
`endif
    t0 = cyc;
    issue(32'h0000_0010, 32'hA5A5_0010, 1'b0);
    issue(32'h0000_0014, 32'hA5A5_0014, 1'b0);
    issue(32'h0000_001C, 32'hA5A5_001C, 1'b0);
    chk("back-to-back cycles", cyc - t0, 32'd3);
    idle(3);
    issue(32'h0000_0110, 32'hA5A5_0110, 1'b1);
    idle(8);
    issue(32'h0000_0010, 32'hA5A5_0010, 1'b1);
    idle(8);
    issue(32'h0000_0210, 32'hA5A5_0210, 1'b1);
    idle(2);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("reset drops mem_data_en", {31'd0, mem_data_en}, 32'd0);
    chk("reset drops mem_addr", mem_addr, 32'd0);
    exp_q.delete();
    mem_q.delete();
    @(negedge clk);
    chk("mid-refill reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid-refill reset resp_data", resp_data, 32'd0);
    reset = 1'b0;
    idle(2);
    issue(32'h0000_0010, 32'hA5A5_0010, 1'b1);
    idle(10);
    chk("resp queue drained", exp_q.size(), 32'd0);
    chk("mem queue drained", mem_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
